// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-system types: RAM status encoding and the machine word.
// Pure type definitions, no logic and no latency.
// Imported by every block on the cache/RAM path.
package cpu_types_pkg;

  // Status reported by the RAM model each cycle
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef logic [31:0] word_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates instruction and data requests onto one single-ported RAM.
// Latency: request seen in IDLE, strobe next cycle; best case 2 cycles per access.
// Backpressure: iwait/dwait held high until the RAM reports ACCESS; ERROR retries in place.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      iREN,
  input  word_t     iaddr,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      iwait,
  output logic      dwait,
  output word_t     iload,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      ramerr
);

  // Counter is at least one bit wide so STARVE_MAX=0 still elaborates
  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2
  } arb_state_t;

  arb_state_t    state;
  arb_state_t    next_state;
  logic [CW-1:0] starve_cnt;
  logic          d_req;
  logic          d_done;
  logic          i_done;
  logic          err_seen;

  assign d_req = dREN | dWEN;

  // Read data is a straight pass-through; the waits qualify it
  assign iload = ramload;
  assign dload = ramload;

  // Next-state, RAM strobes and wait decoding from registered state and live requests.
  // A dropped request takes priority over a same-cycle ACCESS: that cycle is an abort.
  always_comb begin
    next_state = state;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    iwait      = 1'b1;
    dwait      = 1'b1;
    i_done     = 1'b0;
    d_done     = 1'b0;
    err_seen   = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && !(iREN && (starve_cnt == STARVE_LIM))) begin
          next_state = DACC;
        end else if (iREN) begin
          next_state = IACC;
        end
      end
      IACC: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        if (!iREN) begin
          next_state = IDLE;
        end else if (ramstate == ACCESS) begin
          iwait      = 1'b0;
          i_done     = 1'b1;
          next_state = IDLE;
        end else if (ramstate == ERROR) begin
          err_seen = 1'b1;
        end
      end
      DACC: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        if (!d_req) begin
          next_state = IDLE;
        end else if (ramstate == ACCESS) begin
          dwait      = 1'b0;
          d_done     = 1'b1;
          next_state = IDLE;
        end else if (ramstate == ERROR) begin
          err_seen = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register, starvation counter and sticky error flag
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      starve_cnt <= '0;
      ramerr     <= 1'b0;
    end else begin
      state <= next_state;
      if (i_done) begin
        starve_cnt <= '0;
      end else if (d_done && iREN && (starve_cnt != STARVE_LIM)) begin
        starve_cnt <= starve_cnt + CW'(1);
      end
      if (err_seen) begin
        ramerr <= 1'b1;
      end
    end
  end

endmodule
